// File: rtl/sram_like_pkg.sv
// Shared types and constants for the SRAM-like slave endpoint.
package sram_like_pkg;

    localparam logic [3:0] WCNT_MAX = 4'd15;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic        is_write;
        logic [3:0]  age;
        logic [31:0] data;
    } resp_entry_t;

    function automatic logic [3:0] age_inc(input logic [3:0] age, input logic [3:0] lim);
        return (age >= lim) ? lim : age + 4'd1;
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// In-order response buffer: each entry ages every cycle and captures SRAM
// read data the cycle after its access.
module resp_fifo
    import sram_like_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        push_is_write,
    input  logic [31:0] cap_data,
    input  logic        pop,
    output resp_entry_t head,
    output logic        full,
    output logic        empty
);

    localparam int         PW  = $clog2(DEPTH);
    localparam logic [3:0] DLY = 4'(DATA_DELAY);

    resp_entry_t   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Only the most recently pushed entry can be at age 0, so the
            // capture below targets exactly that entry's read data.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i].age <= age_inc(mem[i].age, DLY);
                if (!mem[i].is_write && (mem[i].age == 4'd0)) begin
                    mem[i].data <= cap_data;
                end
            end
            if (push) begin
                mem[wr_ptr] <= '{is_write: push_is_write, age: 4'd0, data: 32'h0};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/sram_like_slave.sv
// SRAM-like request/addr_ok/data_ok endpoint driving a synchronous SRAM,
// with programmable accept delay, response latency and outstanding depth.
module sram_like_slave
    import sram_like_pkg::*;
#(
    parameter int ADDR_OK_DELAY = 1,
    parameter int DATA_DELAY    = 1,
    parameter int DEPTH         = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        sram_en,
    output logic [3:0]  sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    localparam logic [3:0] DLY_M1 = 4'(DATA_DELAY - 1);

    logic [3:0]  wcnt;
    logic        wait_done;
    logic        accept;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    resp_entry_t head;
    logic        unused_size;

    assign unused_size = ^size;

    // Written as wcnt+1 > delay so a zero delay does not fold into a constant compare.
    assign wait_done = ({1'b0, wcnt} + 5'd1) > 5'(ADDR_OK_DELAY);
    assign addr_ok   = req & ~rst & wait_done & ~fifo_full;
    assign accept    = addr_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= '0;
        end else if (!req || accept) begin
            wcnt <= '0;
        end else if (wcnt != WCNT_MAX) begin
            wcnt <= wcnt + 4'd1;
        end
    end

    assign sram_en    = accept;
    assign sram_we    = (accept && wr) ? wstrb : 4'h0;
    assign sram_addr  = addr;
    assign sram_wdata = wdata;

    assign pop     = ~fifo_empty & (head.age == DLY_M1);
    assign data_ok = pop;

    // An entry still at age 0 has not captured its data yet; take it straight from the SRAM.
    always_comb begin
        rdata = 32'h0;
        if (pop && !head.is_write) begin
            rdata = (head.age == 4'd0) ? sram_rdata : head.data;
        end
    end

    resp_fifo #(
        .DEPTH      (DEPTH),
        .DATA_DELAY (DATA_DELAY)
    ) u_resp_fifo (
        .clk           (clk),
        .rst           (rst),
        .push          (accept),
        .push_is_write (wr),
        .cap_data      (sram_rdata),
        .pop           (pop),
        .head          (head),
        .full          (fifo_full),
        .empty         (fifo_empty)
    );

endmodule
